spi_sclk_gen: RTL and testbench

- Upstream stage of the SPI master clock path.
- Divides the system clock into a raw, non-inverted serial clock `Sclk`, idle 0, plus a `clk_en` qualifier. The downstream polarity/phase controller consumes both, applies CKP/CKE and forces the idle level.
- Counts exactly DATA_BITS Sclk periods per transfer.
- Emits rise/fall strobes for the shift/sample logic and a one-cycle done pulse.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_sclk_gen_if.sv | 36 +++
 rtl/spi_half_period_cnt.sv | 30 +++
 rtl/spi_sclk_gen.sv | 153 +++++++++++++++
 tb/tb_spi_sclk_gen.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI clock-path definitions: FSM state encoding and default sizes.
// No logic; constants only.
// Used by the Sclk generator, the shift register and the polarity controller.
package spi_pkg;

  localparam int DIV_W_DEF     = 8;
  localparam int DATA_BITS_DEF = 8;
  localparam int CNT_W_DEF     = 9;

  // SETUP/HOLD are only entered when the chip-select guard is built in.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SETUP = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_t;

endpackage

// File: rtl/spi_sclk_gen_if.sv
// Request/status bundle between the transfer requester and the Sclk generator.
// Pure wiring, zero latency.
// No backpressure: start is a level request, honoured only while busy is low.
// Optional cs_n member is present when SPI_CS_GUARD_EN is defined.
interface spi_sclk_gen_if import spi_pkg::*; #(
  parameter int DIV_W = DIV_W_DEF
);
  logic             start;
  logic [DIV_W-1:0] div;
  logic             busy;
  logic             Sclk;
  logic             clk_en;
  logic             rise_stb;
  logic             fall_stb;
  logic             done;
`ifdef SPI_CS_GUARD_EN
  logic             cs_n;
`endif

  modport master (
    output start, div,
`ifdef SPI_CS_GUARD_EN
    input  cs_n,
`endif
    input  busy, Sclk, clk_en, rise_stb, fall_stb, done
  );

  modport slave (
    input  start, div,
`ifdef SPI_CS_GUARD_EN
    output cs_n,
`endif
    output busy, Sclk, clk_en, rise_stb, fall_stb, done
  );

endinterface

// File: rtl/spi_half_period_cnt.sv
// Loadable half-period counter; tc marks the cycle the count equals limit.
// tc is combinational from the registered count; wrap to 0 takes one cycle.
// No backpressure; counts whenever en is high, load has priority.
module spi_half_period_cnt #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] limit,
  output logic             tc
);

  logic [DIV_W-1:0] cnt_q;

  assign tc = en && (cnt_q == limit);

  // Count 0..limit and wrap, so a period is limit+1 cycles even at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tc ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_sclk_gen.sv
// Raw SPI serial clock generator: divides clk, counts 2*DATA_BITS edges, strobes rise/fall/done.
// busy one cycle after an accepted start; every output registered.
// start ignored while busy; optional chip-select guard phases under SPI_CS_GUARD_EN.
module spi_sclk_gen import spi_pkg::*; #(
  parameter int DIV_W     = DIV_W_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_sclk_gen_if.slave bus
);

  // Toggle index of the final falling edge, before it is counted.
  localparam logic [CNT_W-1:0] TOG_LAST = CNT_W'(2 * DATA_BITS - 1);

  spi_state_t       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] tog_q, tog_d;
  logic             busy_q, busy_d;
  logic             sclk_q, sclk_d;
  logic             clk_en_q, clk_en_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             done_q, done_d;
  logic             load;
  logic             tc;
`ifdef SPI_CS_GUARD_EN
  logic             cs_n_q, cs_n_d;
`endif

  // One counter times the half periods and, with the guard, the setup/hold windows.
  spi_half_period_cnt #(.DIV_W(DIV_W)) u_hp_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .en    (state_q != ST_IDLE),
    .limit (div_q),
    .tc    (tc)
  );

  // Next-state and next-output decode; strobes default low so they last one cycle.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    tog_d    = tog_q;
    busy_d   = busy_q;
    sclk_d   = sclk_q;
    clk_en_d = clk_en_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    done_d   = 1'b0;
    load     = 1'b0;
`ifdef SPI_CS_GUARD_EN
    cs_n_d   = cs_n_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          load   = 1'b1;
          div_d  = bus.div;
          tog_d  = '0;
          busy_d = 1'b1;
`ifdef SPI_CS_GUARD_EN
          state_d  = ST_SETUP;
          cs_n_d   = 1'b0;
`else
          state_d  = ST_RUN;
          clk_en_d = 1'b1;
`endif
        end
      end
      ST_RUN: begin
        if (tc) begin
          sclk_d = ~sclk_q;
          rise_d = ~sclk_q;
          fall_d = sclk_q;
          tog_d  = tog_q + 1'b1;
          if (tog_q == TOG_LAST) begin
            sclk_d   = 1'b0;
            clk_en_d = 1'b0;
`ifdef SPI_CS_GUARD_EN
            state_d  = ST_HOLD;
`else
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
`endif
          end
        end
      end
`ifdef SPI_CS_GUARD_EN
      ST_SETUP: begin
        if (tc) begin
          state_d  = ST_RUN;
          clk_en_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (tc) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts a transfer without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      tog_q    <= '0;
      busy_q   <= 1'b0;
      sclk_q   <= 1'b0;
      clk_en_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SPI_CS_GUARD_EN
      cs_n_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      tog_q    <= tog_d;
      busy_q   <= busy_d;
      sclk_q   <= sclk_d;
      clk_en_q <= clk_en_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      done_q   <= done_d;
`ifdef SPI_CS_GUARD_EN
      cs_n_q   <= cs_n_d;
`endif
    end
  end

  assign bus.busy     = busy_q;
  assign bus.Sclk     = sclk_q;
  assign bus.clk_en   = clk_en_q;
  assign bus.rise_stb = rise_q;
  assign bus.fall_stb = fall_q;
  assign bus.done     = done_q;
`ifdef SPI_CS_GUARD_EN
  assign bus.cs_n     = cs_n_q;
`endif

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Self-checking bench for spi_sclk_gen: directed scenarios then random traffic.
// Expected waveforms come from closed-form timing of each accepted transfer.
// Honours SPI_CS_GUARD_EN by adding the setup/hold windows and cs_n checks.
module tb_spi_sclk_gen;

  localparam int DIV_W     = 8;
  localparam int DATA_BITS = 8;
`ifdef SPI_CS_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk;
  logic rst_n;

  spi_sclk_gen_if #(.DIV_W(DIV_W)) bus ();

  spi_sclk_gen #(.DIV_W(DIV_W), .DATA_BITS(DATA_BITS), .CNT_W(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: the one transfer currently in flight.
  bit m_act = 1'b0;
  int m_ts  = 0;
  int m_dq  = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit m_busy(input int c);
    int rel, p, g;
    if (!m_act) return 1'b0;
    rel = c - m_ts - 1;
    p   = m_dq + 1;
    g   = GUARD ? p : 0;
    return (rel >= 0) && (rel < 2 * g + 2 * DATA_BITS * p);
  endfunction

  task automatic check_outputs();
    int  rel, p, l, g, r;
    logic e_busy, e_en, e_sclk, e_rise, e_fall, e_done;
    e_busy = 1'b0; e_en = 1'b0; e_sclk = 1'b0;
    e_rise = 1'b0; e_fall = 1'b0; e_done = 1'b0;
    if (m_act) begin
      rel    = cyc - m_ts - 1;
      p      = m_dq + 1;
      l      = 2 * DATA_BITS * p;
      g      = GUARD ? p : 0;
      r      = rel - g;
      e_busy = (rel >= 0) && (rel < 2 * g + l);
      e_en   = (r >= 0) && (r < l);
      e_sclk = e_en && ((r / p) % 2 == 1);
      e_rise = e_en && (r % p == 0) && ((r / p) % 2 == 1);
      e_fall = (r > 0) && (r <= l) && (r % p == 0) && ((r / p) % 2 == 0);
      e_done = (rel == 2 * g + l);
    end
    chk("busy",     bus.busy,     e_busy);
    chk("clk_en",   bus.clk_en,   e_en);
    chk("Sclk",     bus.Sclk,     e_sclk);
    chk("rise_stb", bus.rise_stb, e_rise);
    chk("fall_stb", bus.fall_stb, e_fall);
    chk("done",     bus.done,     e_done);
`ifdef SPI_CS_GUARD_EN
    chk("cs_n",     bus.cs_n,     ~e_busy);
`endif
  endtask

  // Drive one cycle of inputs, let the model decide acceptance, check next cycle.
  task automatic tick(input logic s, input logic [DIV_W-1:0] d);
    bus.start = s;
    bus.div   = d;
    if (s && !m_busy(cyc)) begin
      m_act = 1'b1;
      m_ts  = cyc;
      m_dq  = int'(d);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n, input logic [DIV_W-1:0] d);
    for (int i = 0; i < n; i++) tick(1'b0, d);
  endtask

  task automatic reset_pulse();
    bus.start = 1'b0;
    #2;
    rst_n = 1'b0;
    m_act = 1'b0;
    #1;
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.div   = '0;
    @(negedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // div=1 basic transfer
    tick(1'b1, 8'd1);
    idle(36, 8'd1);

    // div=0: Sclk = clk/2
    tick(1'b1, 8'd0);
    idle(20, 8'd0);

    // start held high: re-accepted only in the done cycle
    for (int i = 0; i < 80; i++) tick(1'b1, 8'd1);
    idle(50, 8'd1);

    // div changed mid-transfer, then a transfer at the new setting
    tick(1'b1, 8'd1);
    idle(50, 8'd5);
    tick(1'b1, 8'd5);
    idle(200, 8'd5);

    // asynchronous reset ten cycles into a transfer
    tick(1'b1, 8'd1);
    idle(9, 8'd1);
    reset_pulse();
    tick(1'b1, 8'd1);
    idle(40, 8'd1);

    // random traffic
    for (int i = 0; i < 3000; i++)
      tick(($urandom_range(0, 3) == 0), DIV_W'($urandom_range(0, 6)));
    idle(250, 8'd0);

    // maximum half-period
    tick(1'b1, 8'd255);
    idle(4700, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
